// File: rtl/agex_gshare_predictor.sv
// Gshare branch predictor for AGEX: PHT of saturating counters indexed by PC ^ global history,
// tagged BTB for targets, resolve-time training/redirect, and a post-reset table-clearing walk.
module agex_gshare_predictor #(
  parameter int DBITS        = 32,
  parameter int BHR_BITS     = 8,
  parameter int PT_IDX_BITS  = 8,
  parameter int BTB_IDX_BITS = 6,
  parameter int CNT_BITS     = 2,
  parameter int STAT_BITS    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DBITS-1:0]       fe_pc,
  output logic                   pred_taken,
  output logic [DBITS-1:0]       pred_target,
  output logic [PT_IDX_BITS-1:0] pred_pt_idx,
  input  logic                   ex_valid,
  input  logic                   ex_is_cond,
  input  logic [DBITS-1:0]       ex_pc,
  input  logic                   ex_taken,
  input  logic [DBITS-1:0]       ex_target,
  input  logic [PT_IDX_BITS-1:0] ex_pt_idx,
  input  logic                   ex_pred_taken,
  input  logic [DBITS-1:0]       ex_pred_target,
  output logic                   mispredict,
  output logic [DBITS-1:0]       redirect_pc,
  output logic                   ready,
  output logic [STAT_BITS-1:0]   stat_branches,
  output logic [STAT_BITS-1:0]   stat_mispred
);

  localparam int WALK_W = (PT_IDX_BITS > BTB_IDX_BITS) ? PT_IDX_BITS : BTB_IDX_BITS;
  localparam int PT_N   = 1 << PT_IDX_BITS;
  localparam int BTB_N  = 1 << BTB_IDX_BITS;
  localparam int TAG_W  = DBITS - BTB_IDX_BITS - 2;
  localparam logic [CNT_BITS-1:0] CNT_WNT   = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [WALK_W-1:0]   WALK_LAST = '1;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  function automatic logic [CNT_BITS-1:0] cnt_sat_step(input logic [CNT_BITS-1:0] c,
                                                       input logic up);
    if (up) return (c == '1) ? c : c + CNT_BITS'(1);
    else    return (c == '0) ? c : c - CNT_BITS'(1);
  endfunction

  function automatic logic [STAT_BITS-1:0] stat_sat_inc(input logic [STAT_BITS-1:0] v);
    return (v == '1) ? v : v + STAT_BITS'(1);
  endfunction

  state_t              state_q, state_d;
  logic [WALK_W-1:0]   walk_q, walk_d;
  logic [BHR_BITS-1:0] bhr_q;
  logic [STAT_BITS-1:0] stat_br_q, stat_mp_q;

  logic [CNT_BITS-1:0] pt_mem  [PT_N];
  logic                btb_vld [BTB_N];
  logic [TAG_W-1:0]    btb_tag [BTB_N];
  logic [DBITS-1:0]    btb_tgt [BTB_N];

  logic [BTB_IDX_BITS-1:0] fe_btb_idx, ex_btb_idx;
  logic                    fe_btb_hit, fe_cnt_taken, upd_en;
  logic                    pt_walk_en, btb_walk_en;

  // Table walk: the shorter table is only written while the walk index is in its range
  if (PT_IDX_BITS == WALK_W) begin : g_pt_full
    assign pt_walk_en = 1'b1;
  end else begin : g_pt_part
    assign pt_walk_en = (walk_q[WALK_W-1:PT_IDX_BITS] == '0);
  end

  if (BTB_IDX_BITS == WALK_W) begin : g_btb_full
    assign btb_walk_en = 1'b1;
  end else begin : g_btb_part
    assign btb_walk_en = (walk_q[WALK_W-1:BTB_IDX_BITS] == '0);
  end

  always_comb begin
    state_d = state_q;
    walk_d  = walk_q;
    if (state_q == ST_INIT) begin
      walk_d = walk_q + WALK_W'(1);
      if (walk_q == WALK_LAST) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      walk_q  <= '0;
    end else begin
      state_q <= state_d;
      walk_q  <= walk_d;
    end
  end

  assign ready  = (state_q == ST_READY);
  assign upd_en = ready & ex_valid;

  // Lookup path: purely combinational, reads see pre-update table contents
  assign pred_pt_idx  = fe_pc[PT_IDX_BITS+1:2] ^ PT_IDX_BITS'(bhr_q);
  assign fe_btb_idx   = fe_pc[BTB_IDX_BITS+1:2];
  assign fe_btb_hit   = btb_vld[fe_btb_idx] && (btb_tag[fe_btb_idx] == fe_pc[DBITS-1:BTB_IDX_BITS+2]);
  assign fe_cnt_taken = pt_mem[pred_pt_idx][CNT_BITS-1];
  assign pred_taken   = ready & fe_cnt_taken & fe_btb_hit;
  assign pred_target  = pred_taken ? btb_tgt[fe_btb_idx] : fe_pc + DBITS'(4);

  // Resolve path: valid even during the walk so AGEX can always redirect
  assign mispredict  = ex_valid & ((ex_taken != ex_pred_taken) |
                                   (ex_taken & (ex_pred_target != ex_target)));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + DBITS'(4);
  assign ex_btb_idx  = ex_pc[BTB_IDX_BITS+1:2];

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      if (pt_walk_en)  pt_mem[walk_q[PT_IDX_BITS-1:0]]   <= CNT_WNT;
      if (btb_walk_en) btb_vld[walk_q[BTB_IDX_BITS-1:0]] <= 1'b0;
    end else if (ex_valid) begin
      if (ex_is_cond) pt_mem[ex_pt_idx] <= cnt_sat_step(pt_mem[ex_pt_idx], ex_taken);
      if (ex_taken) begin
        btb_vld[ex_btb_idx] <= 1'b1;
        btb_tag[ex_btb_idx] <= ex_pc[DBITS-1:BTB_IDX_BITS+2];
        btb_tgt[ex_btb_idx] <= ex_target;
      end
    end
  end

  // History shifts only on conditional branches; statistics count every resolved op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bhr_q     <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (upd_en) begin
      if (ex_is_cond) bhr_q <= BHR_BITS'({bhr_q, ex_taken});
      stat_br_q <= stat_sat_inc(stat_br_q);
      if (mispredict) stat_mp_q <= stat_sat_inc(stat_mp_q);
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;

endmodule

// File: tb/tb_agex_gshare_predictor.sv
// Scoreboard bench for agex_gshare_predictor: driver pushes expectations from a behavioural
// model into a queue, a negedge monitor pops and compares the entries due in that cycle.
module tb_agex_gshare_predictor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fe_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_pt_idx;
  logic        ex_valid = 1'b0, ex_is_cond = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
  logic [7:0]  ex_pt_idx = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        ready;
  logic [31:0] stat_branches, stat_mispred;

  agex_gshare_predictor dut (
    .clk(clk), .reset(reset), .fe_pc(fe_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_pt_idx(pred_pt_idx), .ex_valid(ex_valid),
    .ex_is_cond(ex_is_cond), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pt_idx(ex_pt_idx), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .ready(ready),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;   // 0 lookup, 1 resolve, 2 status
    logic [31:0] a, b, c;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  // Behavioural reference state
  int unsigned m_pt[256];
  bit          m_bv[64];
  logic [23:0] m_tag[64];
  logic [31:0] m_tgt[64];
  int unsigned m_bhr, m_br, m_mp, m_cnt;
  bit          m_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        if (e.cyc < cyc) begin
          checks++; failures++;
          $display("FAIL stale_entry cyc=%0d actual=%0d required=%0d", cyc, cyc, e.cyc);
        end else begin
          case (e.kind)
            0: begin
              chk("pred_taken",  {31'b0, pred_taken}, e.a);
              chk("pred_target", pred_target, e.b);
              chk("pred_pt_idx", {24'b0, pred_pt_idx}, e.c);
            end
            1: begin
              chk("mispredict",  {31'b0, mispredict}, e.a);
              chk("redirect_pc", redirect_pc, e.b);
            end
            default: begin
              chk("ready",         {31'b0, ready}, e.a);
              chk("stat_branches", stat_branches, e.b);
              chk("stat_mispred",  stat_mispred, e.c);
            end
          endcase
        end
      end
    end
  end

  function automatic void m_lookup(input logic [31:0] pc, output bit tk,
                                   output logic [31:0] tgt, output logic [7:0] idx);
    int unsigned i, b;
    bit hit;
    i   = ((pc >> 2) & 255) ^ m_bhr;
    b   = (pc >> 2) & 63;
    hit = m_bv[b] && (m_tag[b] == pc[31:8]);
    tk  = m_ready && (m_pt[i] >= 2) && hit;
    tgt = tk ? m_tgt[b] : pc + 32'd4;
    idx = i[7:0];
  endfunction

  // Called at posedge+1; releases reset at a later posedge+1
  task automatic pulse_reset(input int n);
    reset = 1'b1;
    fe_pc = '0; ex_valid = 0; ex_is_cond = 0; ex_taken = 0; ex_pred_taken = 0;
    ex_pc = '0; ex_target = '0; ex_pred_target = '0; ex_pt_idx = '0;
    sbq.push_back('{cyc, 0, 32'd0, 32'd4, 32'd0});
    sbq.push_back('{cyc, 1, 32'd0, 32'd4, 32'd0});
    sbq.push_back('{cyc, 2, 32'd0, 32'd0, 32'd0});
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    m_bhr = 0; m_br = 0; m_mp = 0; m_cnt = 0; m_ready = 0;
  endtask

  task automatic drive(input logic [31:0] fe, input bit v, input bit cond, input logic [31:0] pc,
                       input bit tk, input logic [31:0] tg, input logic [7:0] pidx,
                       input bit ptk, input logic [31:0] ptg);
    bit lt, mp;
    logic [31:0] ltg;
    logic [7:0] lidx;
    int unsigned b;
    fe_pc = fe; ex_valid = v; ex_is_cond = cond; ex_pc = pc; ex_taken = tk;
    ex_target = tg; ex_pt_idx = pidx; ex_pred_taken = ptk; ex_pred_target = ptg;
    m_lookup(fe, lt, ltg, lidx);
    mp = v && ((tk != ptk) || (tk && (ptg != tg)));
    sbq.push_back('{cyc, 0, {31'b0, lt}, ltg, {24'b0, lidx}});
    sbq.push_back('{cyc, 1, {31'b0, mp}, tk ? tg : pc + 32'd4, 32'd0});
    sbq.push_back('{cyc, 2, {31'b0, m_ready}, m_br, m_mp});
    if (m_ready) begin
      if (v) begin
        if (cond) begin
          if (tk && m_pt[pidx] < 3) m_pt[pidx]++;
          if (!tk && m_pt[pidx] > 0) m_pt[pidx]--;
          m_bhr = ((m_bhr << 1) | tk) & 255;
        end
        if (tk) begin
          b = (pc >> 2) & 63;
          m_bv[b] = 1; m_tag[b] = pc[31:8]; m_tgt[b] = tg;
        end
        if (m_br != 32'hFFFF_FFFF) m_br++;
        if (mp && m_mp != 32'hFFFF_FFFF) m_mp++;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 256) begin
        m_ready = 1;
        for (int i = 0; i < 256; i++) m_pt[i] = 1;
        for (int i = 0; i < 64; i++) m_bv[i] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 6))
      0: return 32'h100;
      1: return 32'h1100;
      2: return 32'h200;
      3: return 32'h104;
      4: return 32'h2100;
      5: return 32'h400;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  function automatic logic [31:0] pick_tgt();
    case ($urandom_range(0, 3))
      0: return 32'h80;
      1: return 32'h300;
      2: return 32'h340;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic rand_op(input bit allow_valid);
    logic [31:0] fe, pc, tg, ptg;
    logic [7:0] pidx;
    bit v, ptk;
    fe = pick_pc(); pc = pick_pc(); tg = pick_tgt();
    v = allow_valid && ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 1) == 1) m_lookup(pc, ptk, ptg, pidx);
    else begin
      ptk = 1'($urandom); ptg = pick_tgt(); pidx = 8'($urandom);
    end
    drive(fe, v, 1'($urandom), pc, 1'($urandom), tg, pidx, ptk, ptg);
  endtask

  initial begin : stim
    @(posedge clk); #1;
    pulse_reset(3);
    // Interrupted walk, then a full walk with resolve traffic that must not train
    repeat (100) rand_op(1'b1);
    pulse_reset(2);
    repeat (256) rand_op(1'b1);
    // Conditional BEQ at 0x100 taken twice
    drive(32'h100, 1, 1, 32'h100, 1, 32'h80, 8'h40, 0, 32'h104);
    drive(32'h100, 1, 1, 32'h100, 1, 32'h80, 8'h40, 0, 32'h104);
    // Eight not-taken on a cold entry: saturates low, flushes history back to zero
    repeat (8) drive(32'h400, 1, 1, 32'h400, 0, 32'h0, 8'h10, 0, 32'h404);
    drive(32'h100, 0, 0, 32'h0, 0, 32'h0, 8'h0, 0, 32'h0);
    // Alias: same BTB index, different tag
    drive(32'h1100, 0, 0, 32'h0, 0, 32'h0, 8'h0, 0, 32'h0);
    // JALR target change, history untouched
    drive(32'h200, 1, 0, 32'h200, 1, 32'h340, 8'h80, 1, 32'h300);
    drive(32'h100, 0, 0, 32'h0, 0, 32'h0, 8'h0, 0, 32'h0);
    drive(32'h200, 0, 0, 32'h0, 0, 32'h0, 8'h0, 0, 32'h0);
    // PC+4 wrap on both lookup and redirect
    drive(32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 0, 32'h0, 8'h0, 0, 32'h0);
    repeat (1500) rand_op(1'b1);
    drive(32'h0, 0, 0, 32'h0, 0, 32'h0, 8'h0, 0, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
